// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the I2S effect codec.
//   fx_mode_e : per-frame effect selection (pass / attenuate / boost / mute)
//   sat_shl   : left shift with saturation to a signed word of a given width
package audio_fx_pkg;

   typedef enum logic [1:0] {
      FX_PASS  = 2'b00,
      FX_ATTEN = 2'b01,
      FX_BOOST = 2'b10,
      FX_MUTE  = 2'b11
   } fx_mode_e;

   // Shift x left by sh and clamp to [-2^(w-1), 2^(w-1)-1]. Works in 64 bits so a 24-bit
   // sample shifted by up to 31 cannot wrap before the clamp.
   function automatic longint sat_shl(input longint x, input int unsigned sh,
                                      input int unsigned w);
      longint wide;
      longint hi;
      longint lo;
      wide = x <<< sh;
      hi   = (longint'(1) <<< (w - 1)) - 1;
      lo   = -(longint'(1) <<< (w - 1));
      if (wide > hi) begin
         return hi;
      end else if (wide < lo) begin
         return lo;
      end
      return wide;
   endfunction

endpackage

// File: rtl/audio_fx_gain.sv
// Single-channel effect stage, purely combinational.
//   sample_i : signed input sample
//   mode_i   : effect mode
//   shift_i  : gain shift amount for attenuate/boost
//   sample_o : processed sample
module audio_fx_gain
   import audio_fx_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned SHIFT_W  = 3
) (
   input  logic signed [SAMPLE_W-1:0] sample_i,
   input  fx_mode_e                   mode_i,
   input  logic        [SHIFT_W-1:0]  shift_i,
   output logic signed [SAMPLE_W-1:0] sample_o
);

   always_comb begin
      sample_o = '0;
      unique case (mode_i)
         FX_PASS:  sample_o = sample_i;
         FX_ATTEN: sample_o = sample_i >>> shift_i;
         FX_BOOST: sample_o = SAMPLE_W'(sat_shl(longint'(sample_i), 32'(shift_i), SAMPLE_W));
         FX_MUTE:  sample_o = '0;
         default:  sample_o = '0;
      endcase
   end

endmodule

// File: rtl/audio_i2s_fx_codec.sv
// I2S master transceiver for the WM8731 with a per-frame effect stage.
//   iCLK / iRST_N        : audio master clock, async active-low reset
//   iADC_DATA            : codec ADCDAT serial input
//   iMODE/iSHIFT/iSWAP   : effect settings, latched at frame start
//   oAUD_BCK / oAUD_LRCK : generated bit clock and LR clock
//   oAUD_DATA            : codec DACDAT serial output
//   oSAMPLE_L/R, oSAMPLE_VALID : processed samples, one valid pulse per frame
// All state is clocked by iCLK; BCLK edges are used only as rise/fall enables.
module audio_i2s_fx_codec
   import audio_fx_pkg::*;
#(
   parameter int unsigned SAMPLE_W      = 16,
   parameter int unsigned BITS_PER_CH   = 32,
   parameter int unsigned CLK_PER_BCK_H = 3,
   parameter int unsigned SHIFT_W       = 3
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iADC_DATA,
   input  logic [1:0]          iMODE,
   input  logic [SHIFT_W-1:0]  iSHIFT,
   input  logic                iSWAP,
   output logic                oAUD_BCK,
   output logic                oAUD_LRCK,
   output logic                oAUD_DATA,
   output logic [SAMPLE_W-1:0] oSAMPLE_L,
   output logic [SAMPLE_W-1:0] oSAMPLE_R,
   output logic                oSAMPLE_VALID
);

   localparam int unsigned FRAME_BITS = 2 * BITS_PER_CH;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
   localparam int unsigned DIV_W      = (CLK_PER_BCK_H > 1) ? $clog2(CLK_PER_BCK_H) : 1;

   logic [DIV_W-1:0]           div_q, div_d;
   logic                       bck_q, bck_d;
   logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d, bit_cnt_nxt;
   logic [SAMPLE_W-1:0]        rx_sr_q, rx_sr_d;
   logic signed [SAMPLE_W-1:0] raw_l_q, raw_l_d, raw_r_q, raw_r_d;
   fx_mode_e                   mode_q, mode_d, pmode_q, pmode_d;
   logic [SHIFT_W-1:0]         shift_q, shift_d, pshift_q, pshift_d;
   logic                       swap_q, swap_d, pswap_q, pswap_d;
   logic                       proc_q, proc_d;
   logic [SAMPLE_W-1:0]        out_l_q, out_l_d, out_r_q, out_r_d;
   logic                       valid_q, valid_d;
   logic [SAMPLE_W-1:0]        tx_l_q, tx_l_d, tx_r_q, tx_r_d;
   logic                       data_q, data_d;

   logic                       div_wrap, bck_rise, bck_fall, left_end, frame_end;
   logic signed [SAMPLE_W-1:0] fx_l, fx_r;

   function automatic logic is_right(input logic [CNT_W-1:0] cnt);
      return cnt >= CNT_W'(BITS_PER_CH);
   endfunction

   // True for the slot bits that carry sample data (1..SAMPLE_W within either slot).
   function automatic logic in_word(input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] slot;
      slot = is_right(cnt) ? cnt - CNT_W'(BITS_PER_CH) : cnt;
      return (slot >= CNT_W'(1)) && (slot <= CNT_W'(SAMPLE_W));
   endfunction

   // Effects see the settings that were in force while the frame was received (pmode/pshift),
   // not the ones just latched for the frame now starting.
   audio_fx_gain #(.SAMPLE_W(SAMPLE_W), .SHIFT_W(SHIFT_W)) u_gain_l (
      .sample_i (raw_l_q),
      .mode_i   (pmode_q),
      .shift_i  (pshift_q),
      .sample_o (fx_l)
   );

   audio_fx_gain #(.SAMPLE_W(SAMPLE_W), .SHIFT_W(SHIFT_W)) u_gain_r (
      .sample_i (raw_r_q),
      .mode_i   (pmode_q),
      .shift_i  (pshift_q),
      .sample_o (fx_r)
   );

   // Clock divider and frame counter
   always_comb begin
      div_wrap    = (div_q == DIV_W'(CLK_PER_BCK_H - 1));
      bck_rise    = div_wrap & ~bck_q;
      bck_fall    = div_wrap & bck_q;
      div_d       = div_wrap ? '0 : div_q + DIV_W'(1);
      bck_d       = div_wrap ? ~bck_q : bck_q;
      left_end    = bck_fall && (bit_cnt_q == CNT_W'(BITS_PER_CH - 1));
      frame_end   = bck_fall && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
      bit_cnt_nxt = frame_end ? '0 : bit_cnt_q + CNT_W'(1);
      bit_cnt_d   = bck_fall ? bit_cnt_nxt : bit_cnt_q;
   end

   // Receive path and setting latches
   always_comb begin
      rx_sr_d  = rx_sr_q;
      raw_l_d  = raw_l_q;
      raw_r_d  = raw_r_q;
      mode_d   = mode_q;
      shift_d  = shift_q;
      swap_d   = swap_q;
      pmode_d  = pmode_q;
      pshift_d = pshift_q;
      pswap_d  = pswap_q;
      proc_d   = frame_end;
      if (bck_rise && in_word(bit_cnt_q)) begin
         rx_sr_d = {rx_sr_q[SAMPLE_W-2:0], iADC_DATA};
      end
      if (left_end) begin
         raw_l_d = rx_sr_q;
      end
      if (frame_end) begin
         raw_r_d  = rx_sr_q;
         pmode_d  = mode_q;
         pshift_d = shift_q;
         pswap_d  = swap_q;
         mode_d   = fx_mode_e'(iMODE);
         shift_d  = iSHIFT;
         swap_d   = iSWAP;
      end
   end

   // Processed outputs and transmit path
   always_comb begin
      out_l_d = out_l_q;
      out_r_d = out_r_q;
      valid_d = proc_q;
      tx_l_d  = tx_l_q;
      tx_r_d  = tx_r_q;
      data_d  = data_q;
      if (proc_q) begin
         out_l_d = pswap_q ? fx_r : fx_l;
         out_r_d = pswap_q ? fx_l : fx_r;
      end
      // DACDAT changes together with the BCLK fall that starts the next slot bit.
      if (bck_fall) begin
         data_d = 1'b0;
         if (in_word(bit_cnt_nxt)) begin
            if (is_right(bit_cnt_nxt)) begin
               data_d = tx_r_q[SAMPLE_W-1];
               tx_r_d = {tx_r_q[SAMPLE_W-2:0], 1'b0};
            end else begin
               data_d = tx_l_q[SAMPLE_W-1];
               tx_l_d = {tx_l_q[SAMPLE_W-2:0], 1'b0};
            end
         end
      end
      // Load lands at bit 0 of the new frame, well before the first data bit is shifted.
      if (proc_q) begin
         tx_l_d = out_l_d;
         tx_r_d = out_r_d;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         div_q     <= '0;
         bck_q     <= 1'b0;
         bit_cnt_q <= '0;
         rx_sr_q   <= '0;
         raw_l_q   <= '0;
         raw_r_q   <= '0;
         mode_q    <= FX_PASS;
         shift_q   <= '0;
         swap_q    <= 1'b0;
         pmode_q   <= FX_PASS;
         pshift_q  <= '0;
         pswap_q   <= 1'b0;
         proc_q    <= 1'b0;
         out_l_q   <= '0;
         out_r_q   <= '0;
         valid_q   <= 1'b0;
         tx_l_q    <= '0;
         tx_r_q    <= '0;
         data_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         bck_q     <= bck_d;
         bit_cnt_q <= bit_cnt_d;
         rx_sr_q   <= rx_sr_d;
         raw_l_q   <= raw_l_d;
         raw_r_q   <= raw_r_d;
         mode_q    <= mode_d;
         shift_q   <= shift_d;
         swap_q    <= swap_d;
         pmode_q   <= pmode_d;
         pshift_q  <= pshift_d;
         pswap_q   <= pswap_d;
         proc_q    <= proc_d;
         out_l_q   <= out_l_d;
         out_r_q   <= out_r_d;
         valid_q   <= valid_d;
         tx_l_q    <= tx_l_d;
         tx_r_q    <= tx_r_d;
         data_q    <= data_d;
      end
   end

   assign oAUD_BCK      = bck_q;
   assign oAUD_LRCK     = is_right(bit_cnt_q);
   assign oAUD_DATA     = data_q;
   assign oSAMPLE_L     = out_l_q;
   assign oSAMPLE_R     = out_r_q;
   assign oSAMPLE_VALID = valid_q;

endmodule

// File: tb/tb_audio_i2s_fx_codec.sv
// Bench for audio_i2s_fx_codec. A timeline model derives BCLK/LRCK/DACDAT and the processed
// samples from the count of iCLK edges since reset release, a per-frame table of codec words
// and the settings present at each frame start.
module tb_audio_i2s_fx_codec;

   localparam int FRAME = 384;
   localparam int BCK   = 6;

   logic        iCLK;
   logic        iRST_N;
   logic        iADC_DATA;
   logic [1:0]  iMODE;
   logic [2:0]  iSHIFT;
   logic        iSWAP;
   logic        oAUD_BCK;
   logic        oAUD_LRCK;
   logic        oAUD_DATA;
   logic [15:0] oSAMPLE_L;
   logic [15:0] oSAMPLE_R;
   logic        oSAMPLE_VALID;

   audio_i2s_fx_codec #(
      .SAMPLE_W      (16),
      .BITS_PER_CH   (32),
      .CLK_PER_BCK_H (3),
      .SHIFT_W       (3)
   ) dut (
      .iCLK          (iCLK),
      .iRST_N        (iRST_N),
      .iADC_DATA     (iADC_DATA),
      .iMODE         (iMODE),
      .iSHIFT        (iSHIFT),
      .iSWAP         (iSWAP),
      .oAUD_BCK      (oAUD_BCK),
      .oAUD_LRCK     (oAUD_LRCK),
      .oAUD_DATA     (oAUD_DATA),
      .oSAMPLE_L     (oSAMPLE_L),
      .oSAMPLE_R     (oSAMPLE_R),
      .oSAMPLE_VALID (oSAMPLE_VALID)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   int errors = 0;
   int checks = 0;
   int n      = 0;   // iCLK rising edges since reset release

   logic [15:0] adc_l [16];
   logic [15:0] adc_r [16];
   int          cfg_mode [16];
   int          cfg_sh   [16];
   int          cfg_sw   [16];
   logic [15:0] exp_l, exp_r, exp_tx_l, exp_tx_r;
   logic        exp_v, exp_d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t n=%0d)", name, act, req, $time, n);
      end
   endtask

   function automatic int fx1(input int mode, input int sh, input logic [15:0] w);
      int x;
      int y;
      x = int'($signed(w));
      case (mode)
         0: return x;
         1: return x >>> sh;
         2: begin
            y = x * (1 << sh);
            if (y > 32767) return 32767;
            if (y < -32768) return -32768;
            return y;
         end
         default: return 0;
      endcase
   endfunction

   // Reference timeline, codec ADC driver and per-cycle compare.
   initial begin : model
      int f, g, bi, k, ll, rr, t;
      logic [15:0] w;
      exp_l = '0; exp_r = '0; exp_tx_l = '0; exp_tx_r = '0; exp_v = 1'b0; exp_d = 1'b0;
      forever begin
         @(negedge iCLK);
         if (!iRST_N) begin
            n = 0;
            cfg_mode[0] = 0; cfg_sh[0] = 0; cfg_sw[0] = 0;
            exp_l = '0; exp_r = '0; exp_tx_l = '0; exp_tx_r = '0;
            iADC_DATA = 1'b0;
         end else begin
            n++;
            f = n / FRAME;
            if (n % FRAME == 0 && f < 16) begin
               cfg_mode[f] = int'(iMODE);
               cfg_sh[f]   = int'(iSHIFT);
               cfg_sw[f]   = int'(iSWAP);
            end
            exp_v = (n >= FRAME) && (n % FRAME == 1);
            if (exp_v) begin
               g  = (f - 1) % 16;
               ll = fx1(cfg_mode[g], cfg_sh[g], adc_l[g]);
               rr = fx1(cfg_mode[g], cfg_sh[g], adc_r[g]);
               if (cfg_sw[g] != 0) begin
                  t = ll; ll = rr; rr = t;
               end
               exp_l = 16'(ll); exp_r = 16'(rr);
               exp_tx_l = exp_l; exp_tx_r = exp_r;
            end
            bi = (n / BCK) % 64;
            k  = bi % 32;
            w  = (bi >= 32) ? exp_tx_r : exp_tx_l;
            exp_d = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
            chk("bck",   oAUD_BCK,      ((n / 3) % 2 == 1) ? 1 : 0);
            chk("lrck",  oAUD_LRCK,     (bi >= 32) ? 1 : 0);
            chk("dacdat", oAUD_DATA,    exp_d);
            chk("valid", oSAMPLE_VALID, exp_v);
            chk("sample_l", oSAMPLE_L,  exp_l);
            chk("sample_r", oSAMPLE_R,  exp_r);
            // Drive the codec word for the next BCLK rise; outside the word drive 1s,
            // which the receiver must ignore.
            w = (bi >= 32) ? adc_r[f % 16] : adc_l[f % 16];
            iADC_DATA = (k >= 1 && k <= 16) ? w[16-k] : 1'b1;
         end
      end
   end

   task automatic wait_n(input int target);
      int guard;
      guard = 0;
      while (n < target && guard < 20000) begin
         @(negedge iCLK);
         #1;
         guard++;
      end
      checks++;
      if (n != target) begin
         errors++;
         $display("FAIL wait_n: reached n=%0d required %0d", n, target);
      end
   endtask

   task automatic set_fx(input logic [1:0] m, input logic [2:0] sh, input logic sw);
      iMODE = m; iSHIFT = sh; iSWAP = sw;
   endtask

   task automatic chk_samples(input string name, input logic [15:0] l, input logic [15:0] r);
      chk({name, "_valid"}, oSAMPLE_VALID, 1);
      chk({name, "_l"}, oSAMPLE_L, l);
      chk({name, "_r"}, oSAMPLE_R, r);
   endtask

   initial begin : main
      iRST_N = 1'b0;
      set_fx(2'd0, 3'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         adc_l[i] = 16'h0000; adc_r[i] = 16'h0000;
      end
      adc_l[0] = 16'h1234; adc_r[0] = 16'hABCD;
      adc_l[1] = 16'h8000; adc_r[1] = 16'h0010;
      adc_l[2] = 16'h1000; adc_r[2] = 16'hF000;
      adc_l[3] = 16'h0010; adc_r[3] = 16'hC000;
      adc_l[4] = 16'h1111; adc_r[4] = 16'h2222;
      adc_l[5] = 16'h1111; adc_r[5] = 16'h2222;
      adc_l[6] = 16'h5A5A; adc_r[6] = 16'hA5A5;
      adc_l[7] = 16'h0F0F; adc_r[7] = 16'hF0F0;
      adc_l[8] = 16'h7777; adc_r[8] = 16'h8888;
      repeat (3) @(negedge iCLK);
      #1;
      chk("rst_bck", oAUD_BCK, 0);
      chk("rst_data", oAUD_DATA, 0);
      chk("rst_valid", oSAMPLE_VALID, 0);
      iRST_N = 1'b1;

      wait_n(3);    chk("bck_first_rise", oAUD_BCK, 1);
      wait_n(6);    chk("bck_first_fall", oAUD_BCK, 0);
      wait_n(100);  set_fx(2'd1, 3'd2, 1'b0);           // frame 1: ATTEN 2
      wait_n(191);  chk("lrck_left_end", oAUD_LRCK, 0);
      wait_n(192);  chk("lrck_right_start", oAUD_LRCK, 1);
      wait_n(385);  chk_samples("pass", 16'h1234, 16'hABCD);
      wait_n(386);  chk("pass_valid_once", oSAMPLE_VALID, 0);
      wait_n(404);  chk("dac_l_bit3", oAUD_DATA, 0);
      wait_n(410);  chk("dac_l_bit4", oAUD_DATA, 1);
      wait_n(484);  set_fx(2'd2, 3'd3, 1'b0);           // frame 2: BOOST 3
      wait_n(584);  chk("dac_r_msb", oAUD_DATA, 1);
      wait_n(769);  chk_samples("atten", 16'hE000, 16'h0004);
      wait_n(818);  set_fx(2'd3, 3'd0, 1'b0);           // transient, overwritten before wrap
      wait_n(1068); set_fx(2'd2, 3'd3, 1'b0);           // frame 3: BOOST 3
      wait_n(1153); chk_samples("boost_sat", 16'h7FFF, 16'h8000);
      wait_n(1252); set_fx(2'd3, 3'd0, 1'b1);           // frame 4: MUTE + swap
      wait_n(1537); chk_samples("boost", 16'h0080, 16'h8000);
      wait_n(1636); set_fx(2'd0, 3'd0, 1'b1);           // frame 5: PASS + swap
      wait_n(1921); chk_samples("mute_swap", 16'h0000, 16'h0000);
      wait_n(2020); set_fx(2'd0, 3'd0, 1'b0);           // frame 6: PASS
      wait_n(2305); chk_samples("pass_swap", 16'h2222, 16'h1111);
      wait_n(2404); set_fx(2'd3, 3'd0, 1'b0);           // mid-left of frame 6 -> frame 7 MUTE
      wait_n(2689); chk_samples("midframe_unmuted", 16'h5A5A, 16'hA5A5);
      wait_n(3073); chk_samples("next_frame_muted", 16'h0000, 16'h0000);

      // Reset in the right slot of frame 8.
      wait_n(3322);
      chk("pre_rst_lrck", oAUD_LRCK, 1);
      #2;
      iRST_N = 1'b0;
      #1;
      chk("async_rst_bck", oAUD_BCK, 0);
      chk("async_rst_lrck", oAUD_LRCK, 0);
      chk("async_rst_data", oAUD_DATA, 0);
      chk("async_rst_l", oSAMPLE_L, 0);
      chk("async_rst_r", oSAMPLE_R, 0);
      chk("async_rst_valid", oSAMPLE_VALID, 0);
      repeat (3) @(negedge iCLK);
      #1;
      iRST_N = 1'b1;
      wait_n(2);    chk("restart_lrck", oAUD_LRCK, 0);
      wait_n(385);  chk_samples("restart_pass", 16'h1234, 16'hABCD);
      wait_n(769);  chk_samples("restart_mute", 16'h0000, 16'h0000);
      wait_n(780);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
